ddr2_rd_sched: RTL and testbench

Read-command scheduler in front of the DDR2 controller local interface. It arbitrates round-robin between NUM_REQ read requesters and splits each accepted request into fixed-size local read bursts. For every accepted request it pushes the transfer length into the read-return block's size FIFO (rd_ddr2_size / rd_ddr2_size_wrreq). New requests are admitted only while that block asserts read_permit.

---
 rtl/ddr2_ctrl_pkg.sv | 19 +
 rtl/ddr2_rr_arbiter.sv | 31 +++
 rtl/ddr2_rd_sched.sv | 139 +++++++++++++
 tb/tb_ddr2_rd_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_ctrl_pkg.sv
// Shared constants, state encoding and length check for the DDR2 read-command scheduler.
package ddr2_ctrl_pkg;

  localparam int LEN_W        = 7;
  localparam int MAX_LEN      = 124;
  localparam int LOCAL_SIZE_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  // A transfer must be a whole number of 4-word groups between 4 and MAX_LEN.
  function automatic logic len_legal(input logic [LEN_W-1:0] len);
    return (len >= 7'd4) && (len <= 7'(MAX_LEN)) && (len[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ddr2_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping around.
module ddr2_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [1:0]         ptr,
  output logic [1:0]         sel,
  output logic               any_valid
);

  logic [3:0] vld_pad;
  logic [2:0] idx;

  assign vld_pad = 4'(req_valid);

  // ptr is always below NUM_REQ, so a single subtraction wraps the index.
  always_comb begin
    sel       = 2'd0;
    any_valid = 1'b0;
    idx       = 3'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + 3'(k);
      if (idx >= 3'(NUM_REQ)) idx = idx - 3'(NUM_REQ);
      if (!any_valid && vld_pad[idx[1:0]]) begin
        any_valid = 1'b1;
        sel       = idx[1:0];
      end
    end
  end

endmodule

// File: rtl/ddr2_rd_sched.sv
// Round-robin read scheduler: grants one requester, pushes its length downstream,
// then issues req_len/BURST_LEN local read commands.
module ddr2_rd_sched
  import ddr2_ctrl_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 24,
  parameter int BURST_LEN = 4
) (
  input  logic                      ddr2_clk,
  input  logic                      sys_rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      req_err,
  output logic [1:0]                grant_id,
  input  logic                      read_permit,
  output logic [LEN_W-1:0]          rd_ddr2_size,
  output logic                      rd_ddr2_size_wrreq,
  input  logic                      local_ready,
  output logic                      local_read_req,
  output logic                      local_burstbegin,
  output logic [ADDR_W-1:0]         local_address,
  output logic [LOCAL_SIZE_W-1:0]   local_size,
  output logic                      busy
);

  state_t              state_reg, state_next;
  logic [1:0]          ptr_reg;
  logic [1:0]          grant_id_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [LEN_W-1:0]    remaining_reg;

  logic [1:0]          sel;
  logic                any_valid;
  logic [LEN_W-1:0]    len_arr  [4];
  logic [ADDR_W-1:0]   addr_arr [4];
  logic [LEN_W-1:0]    len_sel;
  logic [ADDR_W-1:0]   addr_sel;
  logic                len_ok;
  logic                last_cmd;
  logic                start;

  // Pad to four slots so a 2-bit index never selects past the array.
  for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
    if (gi < NUM_REQ) begin : g_used
      assign len_arr[gi]  = req_len[gi*LEN_W +: LEN_W];
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    end else begin : g_pad
      assign len_arr[gi]  = '0;
      assign addr_arr[gi] = '0;
    end
  end

  ddr2_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr_reg),
    .sel       (sel),
    .any_valid (any_valid)
  );

  assign len_sel  = len_arr[grant_id_reg];
  assign addr_sel = addr_arr[grant_id_reg];
  assign len_ok   = len_legal(len_sel);
  assign last_cmd = (remaining_reg == LEN_W'(BURST_LEN));
  assign start    = read_permit && any_valid;

  always_ff @(posedge ddr2_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_reg <= ST_IDLE;
    else            state_reg <= state_next;
  end

  always_comb begin
    state_next         = state_reg;
    req_ack            = '0;
    req_err            = 1'b0;
    rd_ddr2_size_wrreq = 1'b0;
    rd_ddr2_size       = '0;
    local_read_req     = 1'b0;
    local_address      = '0;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_GRANT;
      end
      ST_GRANT: begin
        req_ack = NUM_REQ'(1) << grant_id_reg;
        if (len_ok) begin
          rd_ddr2_size_wrreq = 1'b1;
          rd_ddr2_size       = len_sel;
          state_next         = ST_ISSUE;
        end else begin
          req_err    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        local_read_req = 1'b1;
        local_address  = addr_reg;
        if (local_ready && last_cmd) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // grant_id is loaded on the way into GRANT so it is already valid with req_ack.
  always_ff @(posedge ddr2_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ptr_reg       <= 2'd0;
      grant_id_reg  <= 2'd0;
      addr_reg      <= '0;
      remaining_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) grant_id_reg <= sel;
        end
        ST_GRANT: begin
          ptr_reg       <= (grant_id_reg == 2'(NUM_REQ-1)) ? 2'd0 : grant_id_reg + 2'd1;
          addr_reg      <= addr_sel;
          remaining_reg <= len_sel;
        end
        ST_ISSUE: begin
          if (local_ready) begin
            addr_reg      <= addr_reg + ADDR_W'(BURST_LEN);
            remaining_reg <= remaining_reg - LEN_W'(BURST_LEN);
          end
        end
        default: ;
      endcase
    end
  end

  assign local_burstbegin = local_read_req;
  assign local_size       = LOCAL_SIZE_W'(BURST_LEN);
  assign grant_id         = grant_id_reg;
  assign busy             = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ddr2_rd_sched.sv
// Directed bench for ddr2_rd_sched: grants, pushes and issued commands against hand-computed values.
module tb_ddr2_rd_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [23:0] addr0, addr1;
  logic [6:0]  len0, len1;
  logic [1:0]  req_ack;
  logic        req_err;
  logic [1:0]  grant_id;
  logic        read_permit;
  logic [6:0]  rd_ddr2_size;
  logic        rd_ddr2_size_wrreq;
  logic        local_ready;
  logic        local_read_req;
  logic        local_burstbegin;
  logic [23:0] local_address;
  logic [2:0]  local_size;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [23:0] cmd_q[$];
  int          ack_q[$];
  int          size_q[$];
  int          push_cnt, err_cnt;

  always #5 clk = ~clk;

  ddr2_rd_sched #(.NUM_REQ(2), .ADDR_W(24), .BURST_LEN(4)) dut (
    .ddr2_clk           (clk),
    .sys_rst_n          (rst_n),
    .req_valid          (req_valid),
    .req_addr           ({addr1, addr0}),
    .req_len            ({len1, len0}),
    .req_ack            (req_ack),
    .req_err            (req_err),
    .grant_id           (grant_id),
    .read_permit        (read_permit),
    .rd_ddr2_size       (rd_ddr2_size),
    .rd_ddr2_size_wrreq (rd_ddr2_size_wrreq),
    .local_ready        (local_ready),
    .local_read_req     (local_read_req),
    .local_burstbegin   (local_burstbegin),
    .local_address      (local_address),
    .local_size         (local_size),
    .busy               (busy)
  );

  // Transaction monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (|req_ack) begin
        ack_q.push_back(int'(grant_id));
        if (req_err) err_cnt++;
        $display("grant id=%0d err=%0b", grant_id, req_err);
      end
      if (rd_ddr2_size_wrreq) begin
        push_cnt++;
        size_q.push_back(int'(rd_ddr2_size));
      end
      if (local_read_req && local_ready) begin
        cmd_q.push_back(local_address);
        $display("cmd addr=%06h", local_address);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    cmd_q.delete();
    ack_q.delete();
    size_q.delete();
    push_cnt = 0;
    err_cnt  = 0;
  endtask

  // Waits for req_ack[i], then drops that requester's valid; returns negedges waited.
  task automatic wait_ack(input int i, output int cyc);
    bit found = 0;
    cyc = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      cyc++;
      if (req_ack[i]) begin
        found = 1;
        break;
      end
    end
    chk("ack_seen", 32'(found), 32'd1);
    step();
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    chk("idle_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    int c;
    int pc;
    rst_n = 1'b0; req_valid = 2'b00; addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
    read_permit = 1'b1; local_ready = 1'b1;
    clr();
    #12;
    chk("rst_ack",  32'(req_ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req",  32'(local_read_req), 32'd0);
    chk("rst_push", 32'(rd_ddr2_size_wrreq), 32'd0);
    chk("rst_size", 32'(local_size), 32'd4);
    step();
    rst_n = 1'b1;
    step();

    // single request, len 8
    clr();
    addr0 = 24'h000100; len0 = 7'd8; req_valid = 2'b01;
    wait_ack(0, c);
    chk("t1_latency", 32'(c), 32'd2);
    @(negedge clk);
    chk("t1_first_cmd", 32'(local_read_req), 32'd1);
    chk("t1_burstbegin", 32'(local_burstbegin), 32'd1);
    wait_idle();
    chk("t1_ncmd", 32'(cmd_q.size()), 32'd2);
    chk("t1_cmd0", 32'(cmd_q[0]), 32'h100);
    chk("t1_cmd1", 32'(cmd_q[1]), 32'h104);
    chk("t1_push", 32'(push_cnt), 32'd1);
    chk("t1_size", 32'(size_q[0]), 32'd8);

    // contention after reset: pointer restarts at 0
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    clr();
    addr0 = 24'h000200; addr1 = 24'h000300; len0 = 7'd4; len1 = 7'd4; req_valid = 2'b11;
    for (int n = 0; n < 60 && ack_q.size() < 4; n++) @(negedge clk);
    step();
    req_valid = 2'b00;
    wait_idle();
    chk("t2_nack", 32'(ack_q.size()), 32'd4);
    for (int k = 0; k < 4 && k < ack_q.size(); k++) chk("t2_gid", 32'(ack_q[k]), 32'(k % 2));
    chk("t2_push", 32'(push_cnt), 32'd4);
    chk("t2_ncmd", 32'(cmd_q.size()), 32'd4);
    for (int k = 0; k < 4 && k < size_q.size(); k++) chk("t2_size", 32'(size_q[k]), 32'd4);
    if (cmd_q.size() == 4) begin
      chk("t2_cmd0", 32'(cmd_q[0]), 32'h200);
      chk("t2_cmd1", 32'(cmd_q[1]), 32'h300);
    end

    // backpressure on read_permit
    step();
    clr();
    read_permit = 1'b0; addr1 = 24'h000400; len1 = 7'd16; req_valid = 2'b10;
    repeat (10) step();
    chk("t3_noack", 32'(ack_q.size()), 32'd0);
    chk("t3_nopush", 32'(push_cnt), 32'd0);
    read_permit = 1'b1;
    wait_ack(1, c);
    chk("t3_latency", 32'(c), 32'd2);
    read_permit = 1'b0;
    wait_idle();
    chk("t3_ncmd", 32'(cmd_q.size()), 32'd4);
    if (cmd_q.size() == 4) chk("t3_last", 32'(cmd_q[3]), 32'h40C);
    read_permit = 1'b1;

    // ready stall on second command
    step();
    clr();
    addr0 = 24'h000500; len0 = 7'd12; req_valid = 2'b01;
    wait_ack(0, c);
    step();
    local_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_hold_req", 32'(local_read_req), 32'd1);
      chk("t4_hold_addr", 32'(local_address), 32'h504);
    end
    step();
    local_ready = 1'b1;
    wait_idle();
    chk("t4_ncmd", 32'(cmd_q.size()), 32'd3);
    if (cmd_q.size() == 3) chk("t4_cmd2", 32'(cmd_q[2]), 32'h508);

    // illegal lengths on requester 1
    foreach (size_q[k]) ; // keep queue untouched
    for (int k = 0; k < 3; k++) begin
      logic [6:0] bl [3] = '{7'd6, 7'd0, 7'd127};
      step();
      clr();
      len1 = bl[k]; addr1 = 24'h000700; req_valid = 2'b10;
      wait_ack(1, c);
      wait_idle();
      repeat (2) @(negedge clk);
      chk("t5_err", 32'(err_cnt), 32'd1);
      chk("t5_nopush", 32'(push_cnt), 32'd0);
      chk("t5_nocmd", 32'(cmd_q.size()), 32'd0);
    end

    // maximum legal length
    step();
    clr();
    addr0 = 24'h001000; len0 = 7'd124; req_valid = 2'b01;
    wait_ack(0, c);
    wait_idle();
    chk("t5_max_err", 32'(err_cnt), 32'd0);
    chk("t5_max_size", 32'(size_q.size() > 0 ? size_q[0] : -1), 32'd124);
    chk("t5_max_ncmd", 32'(cmd_q.size()), 32'd31);

    // address wrap
    step();
    clr();
    addr1 = 24'hFFFFFC; len1 = 7'd8; req_valid = 2'b10;
    wait_ack(1, c);
    wait_idle();
    chk("t6_ncmd", 32'(cmd_q.size()), 32'd2);
    if (cmd_q.size() == 2) begin
      chk("t6_cmd0", 32'(cmd_q[0]), 32'hFFFFFC);
      chk("t6_cmd1", 32'(cmd_q[1]), 32'h000000);
    end

    // reset mid-burst, then grant restarts from requester 0
    step();
    clr();
    addr1 = 24'h000600; len1 = 7'd32; req_valid = 2'b10;
    wait_ack(1, c);
    @(negedge clk);
    chk("t6_in_issue", 32'(local_read_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", 32'(local_read_req), 32'd0);
    chk("t6_rst_addr", 32'(local_address), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_gid", 32'(grant_id), 32'd0);
    pc = push_cnt;
    repeat (3) step();
    rst_n = 1'b1;
    clr();
    addr0 = 24'h000800; addr1 = 24'h000900; len0 = 7'd4; len1 = 7'd4; req_valid = 2'b11;
    wait_ack(0, c);
    wait_ack(1, c);
    wait_idle();
    chk("t6_pre_push", 32'(pc), 32'd1);
    chk("t6_first_gid", 32'(ack_q.size() > 0 ? ack_q[0] : -1), 32'd0);
    chk("t6_post_ncmd", 32'(cmd_q.size()), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
